// File: rtl/div_seq_ctrl.sv
// Sequencing controller between the EX-stage ALU and the shared multicycle divider.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero bypasses the divider and completes in one cycle.
module div_seq_ctrl #(
  parameter int unsigned TIMEOUT = 48,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_annul,
  output logic        stall,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept  = (state == IDLE) && req && !flush;
  // Gated by rst so the pipeline is released the instant reset asserts.
  assign stall   = rst && (accept || (state == BUSY));
  // A flush arriving in the write cycle kills the HI/LO update.
  assign hilo_we = (state == DONE) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_start   <= 1'b0;
      div_signed  <= 1'b0;
      div_a       <= '0;
      div_b       <= '0;
      div_annul   <= 1'b0;
      hilo_wdata  <= '0;
      timeout_err <= 1'b0;
    end else begin
      div_annul <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            div_a      <= a;
            div_b      <= b;
            div_signed <= req_signed;
            cnt        <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (b == '0) begin
              hilo_wdata <= {a, 32'hFFFF_FFFF};
              state      <= DONE;
            end else begin
              div_start <= 1'b1;
              state     <= BUSY;
            end
`else
            div_start <= 1'b1;
            state     <= BUSY;
`endif
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (flush) begin
            div_annul <= 1'b1;
            div_start <= 1'b0;
            state     <= IDLE;
          end else if (div_ready) begin
            hilo_wdata <= div_result;
            div_start  <= 1'b0;
            state      <= DONE;
          end else if (cnt == CNT_LAST) begin
            // Abort the divider but still retire through DONE so the pipeline moves on.
            div_annul   <= 1'b1;
            timeout_err <= 1'b1;
            div_start   <= 1'b0;
            hilo_wdata  <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing controller between the EX-stage ALU and the shared multicycle divider.
- Accepts DIV/DIVU requests, latches operands and signedness, and holds start to the divider until it reports ready.
- Drives the pipeline stall, issues a one-cycle HI/LO write of the quotient/remainder, and aborts cleanly on exception flush or timeout.
- Replaces the ad-hoc divide handshake that currently lives inside ALU combinational logic.

Parameters:
- TIMEOUT, 48: maximum cycles spent in BUSY without div_ready before abort.
- CNT_W, 6: width of the BUSY cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  EX stage holds a DIV/DIVU op; held stable while stall=1.
- req_signed  in  1  1=DIV, 0=DIVU.
- a  in  32  dividend.
- b  in  32  divisor.
- flush  in  1  exception/flush from MEM; kills any divide in flight.
- div_ready  in  1  divider result valid.
- div_result  in  64  {remainder, quotient} from divider.
- div_start  out  1  start/hold to divider.
- div_signed  out  1  latched signedness to divider.
- div_a  out  32  latched dividend.
- div_b  out  32  latched divisor.
- div_annul  out  1  abort pulse to divider.
- stall  out  1  freeze IF..EX.
- hilo_we  out  1  one-cycle HI/LO write enable.
- hilo_wdata  out  64  {HI=remainder, LO=quotient}.
- timeout_err  out  1  sticky divider-timeout flag, cleared by reset only.

Behaviour:
- States: IDLE, BUSY, DONE. Reset (rst=0, asynchronous) forces IDLE; all registered outputs go to 0, including div_a, div_b, hilo_wdata and the counter.
- stall is combinational: (IDLE & req & ~flush) | BUSY. It is 0 in DONE, so the pipeline advances in the hilo_we cycle.
- IDLE:
  - req=1 and flush=0: latch a, b and req_signed into div_a, div_b and div_signed; clear the counter; go to BUSY.
  - div_start goes high in the next cycle (registered).
  - req=0 or flush=1: stay in IDLE.
- BUSY:
  - div_start=1 is held constant; the counter increments each cycle.
  - Priority order: flush > div_ready > timeout.
  - flush=1: div_annul=1 for exactly one cycle (registered, next cycle); div_start drops; go to IDLE; no hilo_we.
  - div_ready=1: latch div_result into hilo_wdata; drop div_start; go to DONE.
  - Counter reaches TIMEOUT-1 with no ready: pulse div_annul; set timeout_err; go to DONE with hilo_wdata=0 so the pipeline does not hang.
- DONE:
  - hilo_we=1 for exactly one cycle, unless flush=1 in that cycle, which suppresses hilo_we.
  - Always go to IDLE.
  - req is ignored in DONE because it still belongs to the retiring instruction. A back-to-back divide is accepted from IDLE in the following cycle.
- Latched operands never follow a, b or req_signed after acceptance.
- div_ready seen in IDLE or DONE is ignored.
- Write latency: hilo_we occurs in cycle (D+2) after the req-accept cycle, where D is the number of cycles from div_start rising to div_ready.

Optional Feature:
- DIV_ZERO_FAST_EN defined:
  - IDLE with req=1, flush=0 and b==0 skips the divider: div_start stays 0.
  - The controller goes directly to DONE with hilo_wdata={a, 32'hFFFF_FFFF}.
  - stall is 1 for the accept cycle only.
- Not defined: divide-by-zero goes through the divider like any other operand pair, and the result is whatever the divider returns.

Test Plan:
- DIVU, a=100, b=7, divider model ready after 33 cycles:
  - stall=1 continuously from the accept cycle through the ready cycle.
  - hilo_we for one cycle with hilo_wdata=64'h00000002_0000000E.
- DIV, a=32'hFFFF_FFF9 (-7), b=2:
  - hilo_wdata=64'hFFFFFFFF_FFFFFFFD; div_signed=1 throughout BUSY.
- Flush in the 5th BUSY cycle:
  - div_annul is a single pulse; state returns to IDLE; hilo_we is never asserted.
  - A following DIVU 9/3 then yields 64'h00000000_00000003.
- rst=0 asserted mid-BUSY, asynchronously between clock edges:
  - All outputs are 0 immediately; after release, a new request proceeds normally.
- Divider model never asserts ready, TIMEOUT=48:
  - div_annul is pulsed after 48 BUSY cycles; timeout_err=1 and stays set.
  - hilo_we pulses with hilo_wdata=0.
- DIV_ZERO_FAST_EN defined, DIVU a=5, b=0:
  - No div_start; hilo_we in the 2nd cycle with hilo_wdata=64'h00000005_FFFFFFFF.
